// File: rtl/fp_minmax_reduce_d.sv
// Streaming min/max reduction of IEEE-754 doubles with a sticky signaling-NaN flag.
// Define FP_MINMAX_IDX_EN to add out_idx, the position of the winning element.
module fp_minmax_reduce_d #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             minmax,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic             out_nv
`ifdef FP_MINMAX_IDX_EN
   ,
   output logic [CNT_W-1:0] out_idx
`endif
);

   localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [63:0]      acc_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] len_reg;
   logic             mode_reg;
   logic             nv_reg;
   logic [63:0]      data_reg;
   logic             nv_out_reg;

   logic             acc_nan, x_nan, x_snan, both_zero, x_less;
   logic             handshake, last_elem, nv_next;
   logic [63:0]      comb_res;

   // Maps a non-NaN double onto an unsigned key whose order matches IEEE numeric order.
   function automatic logic [63:0] order_key(input logic [63:0] v);
      return v[63] ? ~v : {1'b1, v[62:0]};
   endfunction

   always_comb begin
      acc_nan   = (acc_reg[62:52] == 11'h7FF) && (acc_reg[51:0] != 52'd0);
      x_nan     = (in_data[62:52] == 11'h7FF) && (in_data[51:0] != 52'd0);
      x_snan    = x_nan && !in_data[51];
      both_zero = (acc_reg[62:0] == 63'd0) && (in_data[62:0] == 63'd0);
      x_less    = order_key(in_data) < order_key(acc_reg);
      comb_res  = acc_reg;
      if (acc_nan && x_nan)
         comb_res = QNAN;
      else if (acc_nan)
         comb_res = in_data;
      else if (x_nan)
         comb_res = acc_reg;
      else if (both_zero)
         comb_res = mode_reg ? 64'h0000_0000_0000_0000 : 64'h8000_0000_0000_0000;
      else if (mode_reg)
         comb_res = x_less ? acc_reg : in_data;   // tie goes to the incoming element
      else
         comb_res = x_less ? in_data : acc_reg;   // tie keeps the accumulator
   end

   assign handshake = (state_reg == RUN) && in_valid;
   assign last_elem = (cnt_reg == len_reg - CNT_W'(1));
   assign nv_next   = nv_reg | x_snan;

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start)
               state_next = (len == '0) ? DONE : RUN;
         end
         RUN: begin
            busy     = 1'b1;
            in_ready = 1'b1;
            if (in_valid && last_elem)
               state_next = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         len_reg    <= '0;
         mode_reg   <= 1'b0;
         nv_reg     <= 1'b0;
         data_reg   <= '0;
         nv_out_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && start) begin
            acc_reg  <= QNAN;
            cnt_reg  <= '0;
            nv_reg   <= 1'b0;
            len_reg  <= len;
            mode_reg <= minmax;
            if (len == '0) begin
               data_reg   <= QNAN;
               nv_out_reg <= 1'b0;
            end
         end
         if (handshake) begin
            acc_reg <= comb_res;
            nv_reg  <= nv_next;
            cnt_reg <= cnt_reg + CNT_W'(1);
            // Result registers only move on completion so they hold through IDLE.
            if (last_elem) begin
               data_reg   <= comb_res;
               nv_out_reg <= nv_next;
            end
         end
      end
   end

   assign out_data = data_reg;
   assign out_nv   = nv_out_reg;

`ifdef FP_MINMAX_IDX_EN
   logic [CNT_W-1:0] idx_reg, idx_next, out_idx_reg;

   assign idx_next = (comb_res != acc_reg) ? cnt_reg : idx_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_reg     <= '0;
         out_idx_reg <= '0;
      end else begin
         if (state_reg == IDLE && start) begin
            idx_reg <= '1;
            if (len == '0)
               out_idx_reg <= '1;
         end
         if (handshake) begin
            idx_reg <= idx_next;
            if (last_elem)
               out_idx_reg <= idx_next;
         end
      end
   end

   assign out_idx = out_idx_reg;
`endif

endmodule

// File: tb/tb_fp_minmax_reduce_d.sv
// Directed bench for fp_minmax_reduce_d: real-valued reference model plus literal expectations.
// Honours FP_MINMAX_IDX_EN to connect and check out_idx.
module tb_fp_minmax_reduce_d;
   localparam int          CNT_W = 16;
   localparam logic [63:0] QNAN  = 64'h7FF8_0000_0000_0000;
   localparam logic [CNT_W-1:0] ONES = '1;

   logic             clk = 1'b0;
   logic             rst, start, minmax, in_valid, out_ready;
   logic [CNT_W-1:0] len;
   logic [63:0]      in_data;
   logic             busy, in_ready, out_valid, out_nv;
   logic [63:0]      out_data;
`ifdef FP_MINMAX_IDX_EN
   logic [CNT_W-1:0] out_idx;
`endif

   int tests = 0;
   int fails = 0;
   int vec_no = 0;

   logic [63:0]      exp_data;
   logic             exp_nv;
   logic [CNT_W-1:0] exp_idx;
   logic [63:0]      vq[$];

   always #5 clk = ~clk;

   fp_minmax_reduce_d #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .minmax(minmax), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_nv(out_nv)
`ifdef FP_MINMAX_IDX_EN
      , .out_idx(out_idx)
`endif
   );

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end
   endtask

   function automatic bit is_nan(input logic [63:0] v);
      return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
   endfunction

   function automatic bit is_snan(input logic [63:0] v);
      return is_nan(v) && !v[51];
   endfunction

   // Reference combine using real-number comparison.
   function automatic logic [63:0] combine(input logic [63:0] a, input logic [63:0] x, input bit mx);
      real ra, rx;
      if (is_nan(a) && is_nan(x)) return QNAN;
      if (is_nan(a)) return x;
      if (is_nan(x)) return a;
      if (a[62:0] == 63'd0 && x[62:0] == 63'd0)
         return mx ? 64'h0 : 64'h8000_0000_0000_0000;
      ra = $bitstoreal(a);
      rx = $bitstoreal(x);
      if (mx) return (rx >= ra) ? x : a;
      return (rx < ra) ? x : a;
   endfunction

   // Outputs are meaningful whenever out_valid is high.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         check64("out_data", out_data, exp_data);
         check1("out_nv", out_nv, exp_nv);
`ifdef FP_MINMAX_IDX_EN
         check64("out_idx", 64'(out_idx), 64'(exp_idx));
`endif
      end
   end

   task automatic run_vec(input bit mx, input int gap, input int hold,
                          input logic [63:0] lit_data, input bit lit_nv,
                          input logic [CNT_W-1:0] lit_idx);
      logic [63:0]      acc, nxt;
      bit               nv;
      logic [CNT_W-1:0] idx;
      acc = QNAN; nv = 1'b0; idx = ONES;
      foreach (vq[i]) begin
         nxt = combine(acc, vq[i], mx);
         if (nxt !== acc) idx = CNT_W'(i);
         acc = nxt;
         nv  = nv | is_snan(vq[i]);
      end
      check64("model_data", acc, lit_data);
      check1("model_nv", nv, lit_nv);
      check64("model_idx", 64'(idx), 64'(lit_idx));
      exp_data = acc; exp_nv = nv; exp_idx = idx;
      vec_no++;
      $display("[TB] vec %0d mx=%0d len=%0d gap=%0d hold=%0d expect data=%h nv=%0d idx=%0d",
               vec_no, mx, vq.size(), gap, hold, acc, nv, idx);

      @(posedge clk); #1;
      start = 1'b1; minmax = mx; len = CNT_W'(vq.size());
      @(posedge clk); #1;
      start = 1'b0;
      foreach (vq[i]) begin
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
            check1("gap_out_valid", out_valid, 1'b0);
            check1("gap_busy", busy, 1'b1);
            @(posedge clk); #1;
         end
         in_valid = 1'b1; in_data = vq[i];
         @(negedge clk);
         check1("in_ready", in_ready, 1'b1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      check1("latency_out_valid", out_valid, 1'b1);
      check1("done_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      for (int k = 0; k < hold; k++) begin
         if (k == 2) begin start = 1'b1; len = 16'd7; end
         else start = 1'b0;
         @(negedge clk);
         check1("hold_out_valid", out_valid, 1'b1);
         @(posedge clk); #1;
      end
      start = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      check1("idle_out_valid", out_valid, 1'b0);
      check1("idle_busy", busy, 1'b0);
      check64("retain_out_data", out_data, exp_data);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; minmax = 1'b0; len = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      exp_data = '0; exp_nv = 1'b0; exp_idx = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check1("rst_busy", busy, 1'b0);
      check1("rst_in_ready", in_ready, 1'b0);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_out_nv", out_nv, 1'b0);
      check64("rst_out_data", out_data, 64'h0);
`ifdef FP_MINMAX_IDX_EN
      check64("rst_out_idx", 64'(out_idx), 64'h0);
`endif

      vq = '{64'h3FF0_0000_0000_0000, 64'hC000_0000_0000_0000, 64'h400C_0000_0000_0000};
      run_vec(1'b1, 0, 0, 64'h400C_0000_0000_0000, 1'b0, 16'd2);
      run_vec(1'b0, 0, 0, 64'hC000_0000_0000_0000, 1'b0, 16'd1);
      run_vec(1'b1, 3, 5, 64'h400C_0000_0000_0000, 1'b0, 16'd2);

      vq = '{64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000};
      run_vec(1'b0, 0, 0, 64'h8000_0000_0000_0000, 1'b0, 16'd1);
      run_vec(1'b1, 0, 0, 64'h0000_0000_0000_0000, 1'b0, 16'd0);

      vq = '{64'h7FF8_0000_0000_0001, 64'h4000_0000_0000_0000};
      run_vec(1'b1, 0, 0, 64'h4000_0000_0000_0000, 1'b0, 16'd1);
      vq = '{64'h7FF0_0000_0000_0001, 64'h4000_0000_0000_0000};
      run_vec(1'b1, 0, 0, 64'h4000_0000_0000_0000, 1'b1, 16'd1);

      vq = '{64'hFFF0_0000_0000_0000, 64'h7FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000};
      run_vec(1'b1, 0, 0, 64'h7FF0_0000_0000_0000, 1'b0, 16'd1);
      run_vec(1'b0, 1, 0, 64'hFFF0_0000_0000_0000, 1'b0, 16'd0);

      vq = '{64'h7FF0_0000_0000_0001, 64'h7FF8_0000_0000_0000};
      run_vec(1'b0, 0, 2, QNAN, 1'b1, ONES);

      // Abort a len=4 reduction after two handshakes; out_nv is still 1 from the run above.
      $display("[TB] reset mid-run after 2 of 4 elements");
      @(posedge clk); #1;
      start = 1'b1; minmax = 1'b1; len = 16'd4;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 64'h4010_0000_0000_0000;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check1("abort_busy", busy, 1'b0);
      check1("abort_in_ready", in_ready, 1'b0);
      check1("abort_out_valid", out_valid, 1'b0);
      check1("abort_out_nv", out_nv, 1'b0);

      vq = '{64'h3FF0_0000_0000_0000};
      run_vec(1'b0, 0, 0, 64'h3FF0_0000_0000_0000, 1'b0, 16'd0);

      vq.delete();
      run_vec(1'b1, 0, 1, QNAN, 1'b0, ONES);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
